// File: rtl/periodic_irq_gen_pkg.sv
// Shared definitions for the periodic interrupt generator:
// mode encodings and the channel-index width helper.
package periodic_irq_gen_pkg;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periodic_irq_gen_chan.sv
// One interrupt channel: period counter, pulse/level irq,
// optional rearm on ack and a saturating missed-event counter.
module periodic_irq_chan
    import periodic_irq_gen_pkg::*;
#(
    parameter int CNT_W  = 27,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              en_i,
    input  logic              level_i,
    input  logic              rearm_i,
    input  logic              ack_i,
    output logic              irq_d_o,
    output logic              irq_o,
    output logic [MISS_W-1:0] miss_o
);

    logic [CNT_W-1:0]  period_q, period_d;
    logic              en_q, en_d;
    logic              level_q, level_d;
    logic              rearm_q, rearm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q, irq_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              active;
    logic              fire;

    assign active = en_q && (period_q != '0);
    assign fire   = active && (cnt_q == period_q - CNT_W'(1));

    always_comb begin
        period_d = period_q;
        en_d     = en_q;
        level_d  = level_q;
        rearm_d  = rearm_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        miss_d   = miss_q;
        if (!active) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else begin
            cnt_d = fire ? '0 : cnt_q + CNT_W'(1);
            if (level_q == MODE_PULSE) begin
                irq_d = fire;
            end else begin
                if (rearm_q && ack_i && irq_q)
                    cnt_d = '0;
                // A fire overrides a same-cycle ack and is not a miss
                if (fire) begin
                    irq_d = 1'b1;
                    if (irq_q && !ack_i && (miss_q != '1))
                        miss_d = miss_q + MISS_W'(1);
                end else if (ack_i) begin
                    irq_d = 1'b0;
                end
            end
        end
        if (wr_i) begin
            period_d = period_i;
            en_d     = en_i;
            level_d  = level_i;
            rearm_d  = rearm_i;
            cnt_d    = '0;
            irq_d    = 1'b0;
            miss_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            period_q <= '0;
            en_q     <= 1'b0;
            level_q  <= MODE_PULSE;
            rearm_q  <= 1'b0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            miss_q   <= '0;
        end else begin
            period_q <= period_d;
            en_q     <= en_d;
            level_q  <= level_d;
            rearm_q  <= rearm_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            miss_q   <= miss_d;
        end
    end

    assign irq_d_o = irq_d;
    assign irq_o   = irq_q;
    assign miss_o  = miss_q;

endmodule

// File: rtl/periodic_irq_gen.sv
// Multi-channel periodic interrupt generator: write decode,
// per-channel instances and the registered irq_any reduction.
module periodic_irq_gen
    import periodic_irq_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27,
    parameter int MISS_W = 8,
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [CNT_W-1:0]         cfg_period,
    input  logic                     cfg_en,
    input  logic                     cfg_level,
    input  logic                     cfg_rearm,
    input  logic [NUM_CH-1:0]        ack,
    output logic [NUM_CH-1:0]        irq,
    output logic                     irq_any,
    output logic [NUM_CH*MISS_W-1:0] miss_cnt
);

    logic [NUM_CH-1:0] irq_next;
    logic              irq_any_q;

    // Out-of-range channel indices match no instance and are dropped
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CH_W'(g));

        periodic_irq_chan #(
            .CNT_W  (CNT_W),
            .MISS_W (MISS_W)
        ) u_chan (
            .clk      (clk),
            .srst     (srst),
            .wr_i     (wr),
            .period_i (cfg_period),
            .en_i     (cfg_en),
            .level_i  (cfg_level),
            .rearm_i  (cfg_rearm),
            .ack_i    (ack[g]),
            .irq_d_o  (irq_next[g]),
            .irq_o    (irq[g]),
            .miss_o   (miss_cnt[g*MISS_W +: MISS_W])
        );
    end

    always_ff @(posedge clk) begin
        if (srst)
            irq_any_q <= 1'b0;
        else
            irq_any_q <= |irq_next;
    end

    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_periodic_irq_gen.sv
// Directed bench for periodic_irq_gen: a per-cycle vector table
// plus hand sequences for rearm, pulse period, P=0 and reset.
module tb_periodic_irq_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 27;
    localparam int MISS_W = 2;

    logic                     clk = 1'b0;
    logic                     srst;
    logic                     cfg_we;
    logic [1:0]               cfg_ch;
    logic [CNT_W-1:0]         cfg_period;
    logic                     cfg_en;
    logic                     cfg_level;
    logic                     cfg_rearm;
    logic [NUM_CH-1:0]        ack;
    logic [NUM_CH-1:0]        irq;
    logic                     irq_any;
    logic [NUM_CH*MISS_W-1:0] miss_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    periodic_irq_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .MISS_W (MISS_W)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .cfg_level  (cfg_level),
        .cfg_rearm  (cfg_rearm),
        .ack        (ack),
        .irq        (irq),
        .irq_any    (irq_any),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        logic             we;
        logic [1:0]       ch;
        logic [CNT_W-1:0] p;
        logic             lvl;
        logic [2:0]       ack;
        logic [2:0]       eirq;
        logic [1:0]       em1;
    } vec_t;

    vec_t tbl[22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input int p, input logic en,
                       input logic lvl, input logic rearm);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = CNT_W'(p);
        cfg_en     = en;
        cfg_level  = lvl;
        cfg_rearm  = rearm;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] ch,
                                input int p, input logic lvl,
                                input logic [2:0] a, input logic [2:0] ei,
                                input logic [1:0] m);
        vec_t v;
        v.we = we; v.ch = ch; v.p = CNT_W'(p); v.lvl = lvl;
        v.ack = a; v.eirq = ei; v.em1 = m;
        return v;
    endfunction

    initial begin
        int  n;
        logic bad;

        srst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_en = 1'b0; cfg_level = 1'b0; cfg_rearm = 1'b0; ack = '0;
        tick();
        tick();
        srst = 1'b0;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_any", 32'(irq_any), 32'd0);
        check("reset_miss", 32'(miss_cnt), 32'd0);

        // Pulse mode P=10 on ch0
        cfg(2'd0, 10, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("pulse10_k%0d", k), 32'(irq),
                  (k % 10 == 0) ? 32'd1 : 32'd0);
        end

        // P=0 never fires
        do_reset();
        cfg(2'd2, 0, 1'b1, 1'b0, 1'b0);
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (irq != '0 || irq_any) bad = 1'b1;
        end
        check("p0_never_fires", 32'(bad), 32'd0);

        // Vector table, starting from reset
        do_reset();
        tbl[0]  = mk(1, 0, 3, 0, 3'b000, 3'b000, 0);
        tbl[1]  = mk(1, 1, 2, 1, 3'b000, 3'b000, 0);
        tbl[2]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0);
        tbl[3]  = mk(0, 0, 0, 0, 3'b000, 3'b011, 0);
        tbl[4]  = mk(0, 0, 0, 0, 3'b000, 3'b010, 0);
        tbl[5]  = mk(0, 0, 0, 0, 3'b000, 3'b010, 1);
        tbl[6]  = mk(0, 0, 0, 0, 3'b010, 3'b001, 1);
        tbl[7]  = mk(0, 0, 0, 0, 3'b010, 3'b010, 1);
        tbl[8]  = mk(0, 0, 0, 0, 3'b010, 3'b000, 1);
        tbl[9]  = mk(0, 0, 0, 0, 3'b000, 3'b011, 1);
        tbl[10] = mk(1, 3, 1, 0, 3'b010, 3'b000, 1);
        tbl[11] = mk(1, 2, 1, 0, 3'b000, 3'b010, 1);
        tbl[12] = mk(0, 0, 0, 0, 3'b000, 3'b111, 1);
        tbl[13] = mk(0, 0, 0, 0, 3'b000, 3'b110, 2);
        tbl[14] = mk(0, 0, 0, 0, 3'b010, 3'b100, 2);
        tbl[15] = mk(0, 0, 0, 0, 3'b000, 3'b111, 2);
        tbl[16] = mk(0, 0, 0, 0, 3'b000, 3'b110, 2);
        tbl[17] = mk(0, 0, 0, 0, 3'b010, 3'b110, 2);
        tbl[18] = mk(0, 0, 0, 0, 3'b000, 3'b111, 2);
        tbl[19] = mk(0, 0, 0, 0, 3'b000, 3'b110, 3);
        tbl[20] = mk(0, 0, 0, 0, 3'b000, 3'b110, 3);
        tbl[21] = mk(0, 0, 0, 0, 3'b000, 3'b111, 3);
        for (int i = 0; i < 22; i++) begin
            cfg_we     = tbl[i].we;
            cfg_ch     = tbl[i].ch;
            cfg_period = tbl[i].p;
            cfg_en     = 1'b1;
            cfg_level  = tbl[i].lvl;
            cfg_rearm  = 1'b0;
            ack        = tbl[i].ack;
            tick();
            check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].eirq));
            check($sformatf("tbl%0d_any", i), 32'(irq_any),
                  32'(|tbl[i].eirq));
            check($sformatf("tbl%0d_miss", i), 32'(miss_cnt),
                  32'({2'b00, tbl[i].em1, 2'b00}));
        end
        cfg_we = 1'b0;
        ack    = '0;

        // Level + rearm, P=100, ack 30 cycles after first fire
        do_reset();
        cfg(2'd0, 100, 1'b1, 1'b1, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 99; k++) begin
            tick();
            if (irq[0]) bad = 1'b1;
        end
        check("rearm_early", 32'(bad), 32'd0);
        tick();
        check("rearm_first_fire", 32'(irq[0]), 32'd1);
        for (int k = 0; k < 29; k++) tick();
        check("rearm_held", 32'(irq[0]), 32'd1);
        ack = 3'b001;
        tick();
        ack = '0;
        check("rearm_ack_clears", 32'(irq[0]), 32'd0);
        n = 0;
        while (!irq[0] && n < 200) begin
            tick();
            n++;
        end
        check("rearm_next_fire_gap", 32'(n), 32'd100);
        check("rearm_miss", 32'(miss_cnt), 32'd0);

        // srst with level irqs pending on every channel
        do_reset();
        cfg(2'd0, 2, 1'b1, 1'b1, 1'b0);
        cfg(2'd1, 2, 1'b1, 1'b1, 1'b0);
        cfg(2'd2, 2, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick();
        check("pre_srst_irq", 32'(irq), 32'd7);
        srst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = CNT_W'(1);
        cfg_en = 1'b1; cfg_level = 1'b0; ack = 3'b111;
        tick();
        srst = 1'b0; cfg_we = 1'b0; ack = '0;
        check("srst_irq", 32'(irq), 32'd0);
        check("srst_any", 32'(irq_any), 32'd0);
        check("srst_miss", 32'(miss_cnt), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (irq != '0 || irq_any || miss_cnt != '0) bad = 1'b1;
        end
        check("post_srst_idle", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
